// File: rtl/shift_reg_pkg.sv
// Shared mode encodings and sizing helper for the universal shift register.
package shift_reg_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DN   = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// Control, serial/parallel data and status bundle of the universal shift register.
interface univ_shift_reg_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
);
  import shift_reg_pkg::*;

  localparam int CNT_W = cnt_width(DEPTH);

  logic                   en;
  logic                   clr;
  logic [1:0]             mode;
  logic [WIDTH-1:0]       sin_lo;
  logic [WIDTH-1:0]       sin_hi;
  logic                   sin_vld;
  logic [DEPTH*WIDTH-1:0] pin;
  logic [DEPTH*WIDTH-1:0] pout;
  logic [DEPTH-1:0]       vld;
  logic [WIDTH-1:0]       sout_lo;
  logic [WIDTH-1:0]       sout_hi;
  logic [CNT_W-1:0]       cnt;
  logic                   full;
  logic                   empty;

  modport master (
    output en, clr, mode, sin_lo, sin_hi, sin_vld, pin,
    input  pout, vld, sout_lo, sout_hi, cnt, full, empty
  );

  modport slave (
    input  en, clr, mode, sin_lo, sin_hi, sin_vld, pin,
    output pout, vld, sout_lo, sout_hi, cnt, full, empty
  );

endinterface

// File: rtl/shift_stage.sv
// One register stage: {valid, data} flop selecting hold / lower neighbour / upper neighbour / load.
module shift_stage #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clr,
  input  logic [1:0]   i_sel,
  input  logic [W-1:0] i_d_lo,
  input  logic [W-1:0] i_d_hi,
  input  logic [W-1:0] i_d_ld,
  output logic [W-1:0] o_q
);
  import shift_reg_pkg::*;

  logic [W-1:0] r_q;
  logic [W-1:0] w_d;

  always_comb begin
    // NOTE: default assignment first so every path drives w_d and no latch is inferred.
    w_d = r_q;
    case (i_sel)
      MODE_UP:   w_d = i_d_lo;
      MODE_DN:   w_d = i_d_hi;
      MODE_LOAD: w_d = i_d_ld;
      default:   w_d = r_q;
    endcase
  end

  // NOTE: non-blocking assignments so all stages sample their neighbours' pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     r_q <= '0;
    else if (i_clr) r_q <= '0;
    else            r_q <= w_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: DEPTH tagged stages with shift-up/down, parallel load and occupancy flags.
module univ_shift_reg #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  univ_shift_reg_if.slave bus
);
  import shift_reg_pkg::*;

  localparam int CNT_W = cnt_width(DEPTH);

  logic [WIDTH:0]   w_q [DEPTH];
  logic [1:0]       w_sel;
  logic [CNT_W-1:0] w_cnt;

  // Disabled cycles collapse to HOLD; clr still wins inside each stage.
  assign w_sel = bus.en ? bus.mode : MODE_HOLD;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic [WIDTH:0] w_lo;
    logic [WIDTH:0] w_hi;

    if (g == 0) begin : g_lo_edge
      assign w_lo = {bus.sin_vld, bus.sin_lo};
    end else begin : g_lo_mid
      assign w_lo = w_q[g-1];
    end

    if (g == DEPTH - 1) begin : g_hi_edge
      assign w_hi = {bus.sin_vld, bus.sin_hi};
    end else begin : g_hi_mid
      assign w_hi = w_q[g+1];
    end

    shift_stage #(.W(WIDTH + 1)) u_stage (
      .clk    (clk),
      .reset  (reset),
      .i_clr  (bus.clr),
      .i_sel  (w_sel),
      .i_d_lo (w_lo),
      .i_d_hi (w_hi),
      .i_d_ld ({1'b1, bus.pin[g*WIDTH +: WIDTH]}),
      .o_q    (w_q[g])
    );
  end

  always_comb begin
    bus.pout = '0;
    bus.vld  = '0;
    w_cnt    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      bus.pout[i*WIDTH +: WIDTH] = w_q[i][WIDTH-1:0];
      bus.vld[i]                 = w_q[i][WIDTH];
      w_cnt                      = w_cnt + CNT_W'(w_q[i][WIDTH]);
    end
  end

  assign bus.sout_lo = w_q[0][WIDTH-1:0];
  assign bus.sout_hi = w_q[DEPTH-1][WIDTH-1:0];
  assign bus.cnt     = w_cnt;
  assign bus.full    = (w_cnt == CNT_W'(DEPTH));
  assign bus.empty   = (w_cnt == '0);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg: queue-based reference model, directed scenarios then random traffic.
module tb_univ_shift_reg;
  import shift_reg_pkg::*;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int CNT_W = cnt_width(DEPTH);

  typedef struct packed {
    logic [DEPTH*WIDTH-1:0] pout;
    logic [DEPTH-1:0]       vld;
    logic [WIDTH-1:0]       sout_lo;
    logic [WIDTH-1:0]       sout_hi;
    logic [CNT_W-1:0]       cnt;
    logic                   full;
    logic                   empty;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  univ_shift_reg_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  univ_shift_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Stage i of the model is m_q[i]; each entry is {valid, data}.
  logic [WIDTH:0] m_q[$];
  exp_t           exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
  endtask

  task automatic compare_all(input string tag, input exp_t e);
    check({tag, ".pout"},    32'(bus.pout),    32'(e.pout));
    check({tag, ".vld"},     32'(bus.vld),     32'(e.vld));
    check({tag, ".sout_lo"}, 32'(bus.sout_lo), 32'(e.sout_lo));
    check({tag, ".sout_hi"}, 32'(bus.sout_hi), 32'(e.sout_hi));
    check({tag, ".cnt"},     32'(bus.cnt),     32'(e.cnt));
    check({tag, ".full"},    32'(bus.full),    32'(e.full));
    check({tag, ".empty"},   32'(bus.empty),   32'(e.empty));
  endtask

  task automatic model_clear();
    m_q.delete();
    for (int i = 0; i < DEPTH; i++) m_q.push_back('0);
  endtask

  function automatic exp_t model_exp();
    exp_t e;
    int   n;
    e = '0;
    n = 0;
    for (int i = 0; i < DEPTH; i++) begin
      e.pout[i*WIDTH +: WIDTH] = m_q[i][WIDTH-1:0];
      e.vld[i]                 = m_q[i][WIDTH];
      if (m_q[i][WIDTH]) n++;
    end
    e.sout_lo = m_q[0][WIDTH-1:0];
    e.sout_hi = m_q[DEPTH-1][WIDTH-1:0];
    e.cnt     = CNT_W'(n);
    e.full    = (n == DEPTH);
    e.empty   = (n == 0);
    return e;
  endfunction

  task automatic model_edge(input logic e, input logic c, input logic [1:0] md,
                            input logic [WIDTH-1:0] slo, input logic [WIDTH-1:0] shi,
                            input logic sv, input logic [DEPTH*WIDTH-1:0] pn);
    logic [WIDTH:0] dropped;
    if (c) begin
      model_clear();
    end else if (e) begin
      case (md)
        MODE_UP: begin
          m_q.push_front({sv, slo});
          dropped = m_q.pop_back();
        end
        MODE_DN: begin
          m_q.push_back({sv, shi});
          dropped = m_q.pop_front();
        end
        MODE_LOAD: for (int i = 0; i < DEPTH; i++) m_q[i] = {1'b1, pn[i*WIDTH +: WIDTH]};
        default: ;
      endcase
    end
  endtask

  // Drive one cycle of stimulus, let the edge consume it, then record the expected response.
  task automatic step(input logic e, input logic c, input logic [1:0] md,
                      input logic [WIDTH-1:0] slo, input logic [WIDTH-1:0] shi,
                      input logic sv, input logic [DEPTH*WIDTH-1:0] pn);
    @(negedge clk);
    bus.en      = e;
    bus.clr     = c;
    bus.mode    = md;
    bus.sin_lo  = slo;
    bus.sin_hi  = shi;
    bus.sin_vld = sv;
    bus.pin     = pn;
    @(posedge clk);
    model_edge(e, c, md, slo, shi, sv, pn);
    exp_q.push_back(model_exp());
  endtask

  // Monitor: compare DUT outputs with the oldest pending expectation, away from the active edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compare_all("sb", e);
    end
  end

  always @(posedge clk) begin
    if (reset === 1'b1 && bus.en === 1'b1 && bus.clr === 1'b0)
      assert (!$isunknown(bus.mode)) else $error("mode is X while enabled");
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset       = 1'b0;
    bus.en      = 1'b0;
    bus.clr     = 1'b0;
    bus.mode    = MODE_HOLD;
    bus.sin_lo  = '0;
    bus.sin_hi  = '0;
    bus.sin_vld = 1'b0;
    bus.pin     = '0;
    model_clear();

    // Reset held low for two cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    compare_all("reset", model_exp());
    reset = 1'b1;

    // Disabled after reset: state unchanged.
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, MODE_UP, 4'hF, 4'hF, 1'b1, 16'hFFFF);

    // Fill by shifting up 1..4, then one more while full.
    for (int k = 1; k <= 5; k++) step(1'b1, 1'b0, MODE_UP, WIDTH'(k), 4'h0, 1'b1, 16'h0);

    // Load while full, then drain downward with bubbles, and once more while empty.
    step(1'b1, 1'b0, MODE_LOAD, 4'h0, 4'h0, 1'b0, 16'hA5C3);
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, MODE_DN, 4'h0, 4'h0, 1'b0, 16'h0);

    // clr wins over an enabled load.
    step(1'b1, 1'b0, MODE_LOAD, 4'h0, 4'h0, 1'b0, 16'h1234);
    step(1'b1, 1'b1, MODE_LOAD, 4'h0, 4'h0, 1'b0, 16'hFFFF);

    // Asynchronous reset in the middle of a shift-up stream.
    step(1'b1, 1'b0, MODE_UP, 4'h7, 4'h0, 1'b1, 16'h0);
    step(1'b1, 1'b0, MODE_UP, 4'h8, 4'h0, 1'b1, 16'h0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    model_clear();
    compare_all("async_rst", model_exp());
    @(posedge clk);
    exp_q.push_back(model_exp());
    @(negedge clk);
    #1;
    reset = 1'b1;

    // Bubble insertion, with back-to-back mode changes around it.
    step(1'b1, 1'b1, MODE_HOLD, 4'h0, 4'h0, 1'b0, 16'h0);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, MODE_UP, WIDTH'(k + 9), 4'h0, k[0], 16'h0);
    step(1'b1, 1'b0, MODE_DN,   4'h0, 4'h6, 1'b1, 16'h0);
    step(1'b1, 1'b0, MODE_UP,   4'h3, 4'h0, 1'b0, 16'h0);
    step(1'b1, 1'b0, MODE_HOLD, 4'h1, 4'h2, 1'b1, 16'hBEEF);

    // Random traffic.
    for (int k = 0; k < 300; k++) begin
      step($urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0, 2'($urandom_range(0, 3)),
           WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 16'($urandom));
    end

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
